// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared seven-segment constants (active-low cathode patterns
//                and the blanking code shared with the upstream blink stage).
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low {g,f,e,d,c,b,a} patterns for numerals 0-9
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [6:0] SEG_BLANK  = 7'h7F;  // all cathodes off
  localparam logic [6:0] SEG_DASH   = 7'h3F;  // segment g only
  localparam logic [3:0] CODE_BLANK = 4'd10;  // blink-stage blanking code

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational 4-bit code to active-low segment decoder.
//                0-9 numerals, 10 blank, 11-15 dash.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Dash by default; blank and numerals override
  always_comb begin
    seg = SEG_DASH;
    if (code == CODE_BLANK) begin
      seg = SEG_BLANK;
    end
    for (int i = 0; i < 10; i++) begin
      if (code == 4'(i)) begin
        seg = SEG_DIGIT[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexes four digit codes onto a common-anode 4-digit
//                seven-segment display. Digits are snapshotted once per frame,
//                and each slot begins with an all-anodes-off ghost guard.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50_000,  // cycles per digit slot, >= 2
  parameter int BLANK_CYCLES = 500      // guard cycles per slot, < SCAN_DIV
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic [3:0] pnum0,
  input  logic [3:0] pnum1,
  input  logic [3:0] pnum2,
  input  logic [3:0] pnum3,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int              CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_blank    = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_snap;
  logic [3:0]       r_snap_dp;

  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_idx_next;
  logic             w_wrap;
  logic             w_snap_edge;
  logic [3:0][3:0]  w_snap_next;
  logic [3:0]       w_snap_dp_next;
  logic [3:0]       w_code;
  logic [6:0]       w_seg_dec;
  logic             w_drive;

  // Next slot position and next snapshot. Outputs are computed from these
  // so the registered pins always match the current (cnt, idx) pair.
  always_comb begin
    w_wrap         = (r_cnt == c_cnt_last);
    w_cnt_next     = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_next     = w_wrap ? r_idx + 2'd1 : r_idx;
    w_snap_edge    = w_wrap && (r_idx == 2'd3);
    w_snap_next    = w_snap_edge ? {pnum3, pnum2, pnum1, pnum0} : r_snap;
    w_snap_dp_next = w_snap_edge ? dp_mask : r_snap_dp;
    w_code         = w_snap_next[w_idx_next];
    w_drive        = (w_cnt_next >= c_blank);
  end

  seg7_decode u_decode (
    .code (w_code),
    .seg  (w_seg_dec)
  );

  // Slot counters, frame snapshot and registered display pins
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_snap     <= {NUM_DIGITS{CODE_BLANK}};
      r_snap_dp  <= 4'b0000;
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_snap     <= w_snap_next;
      r_snap_dp  <= w_snap_dp_next;
      frame_tick <= w_snap_edge;
      if (w_drive) begin
        an  <= ~(4'b0001 << w_idx_next);
        seg <= w_seg_dec;
        dp  <= ~w_snap_dp_next[w_idx_next];
      end else begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
